// File: rtl/nco_sweep_ctrl.sv
// NCO phase generator with handshaked config, linear chirp engine, sample strobe divider and TX square wave.
// Optional build macro NCO_PHASE_DITHER_EN adds LFSR phase dither ahead of truncation.
module nco_sweep_ctrl #(
  parameter int ACC_W   = 64,
  parameter int PHASE_W = 10,
  parameter int DIV     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_inc,
  input  logic [PHASE_W-1:0] cfg_offset,
  input  logic               sweep_start,
  input  logic               sweep_abort,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [ACC_W-1:0]   sweep_stop,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic               sample_ce,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               tx_out
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {FIXED, SWEEP, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   inc_active;
  logic [ACC_W-1:0]   pend_inc;
  logic [PHASE_W-1:0] offset;
  logic [PHASE_W-1:0] pend_offset;
  logic               pend_load;
  logic [CNT_W-1:0]   div_cnt;
  logic [ACC_W:0]     sweep_nxt;
  logic [ACC_W-1:0]   start_inc;
  logic [PHASE_W-1:0] phase_top;
  logic               cfg_fire;

  assign sample_ce = (div_cnt == CNT_LAST);
  assign cfg_fire  = cfg_valid && cfg_ready;
  // Extra top bit catches a step that wraps past 2^ACC_W so it clamps instead.
  assign sweep_nxt = {1'b0, inc_active} + {1'b0, sweep_step};
  // A load still in flight decides whether a sweep start is already finished.
  assign start_inc = pend_load ? pend_inc : inc_active;

`ifdef NCO_PHASE_DITHER_EN
  logic [15:0]    lfsr;
  logic           lfsr_fb;
  logic [ACC_W-1:0] dith_acc;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dith_acc = acc + (ACC_W'(lfsr) << (ACC_W - PHASE_W - 16));
  assign phase_top = dith_acc[ACC_W-1 -: PHASE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (sample_ce) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign phase_top = acc[ACC_W-1 -: PHASE_W];
`endif

  // NOTE: every register below uses <= so all updates read pre-edge values,
  // which is what makes the acc -> phase_out path exactly one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      div_cnt     <= '0;
      tx_out      <= 1'b0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
    end else begin
      acc         <= acc + inc_active;
      tx_out      <= acc[ACC_W-1];
      div_cnt     <= sample_ce ? '0 : div_cnt + CNT_W'(1);
      phase_valid <= sample_ce;
      if (sample_ce) begin
        phase_out <= phase_top + offset;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FIXED;
      cfg_ready   <= 1'b1;
      sweep_busy  <= 1'b0;
      sweep_done  <= 1'b0;
      inc_active  <= '0;
      offset      <= '0;
      pend_inc    <= '0;
      pend_offset <= '0;
      pend_load   <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      pend_load  <= cfg_fire;
      if (cfg_fire) begin
        pend_inc    <= cfg_inc;
        pend_offset <= cfg_offset;
      end
      if (pend_load) begin
        inc_active <= pend_inc;
        offset     <= pend_offset;
      end

      case (state)
        FIXED: begin
          // A config handshake in the same cycle takes priority over a start.
          if (sweep_start && !cfg_fire) begin
            cfg_ready <= 1'b0;
            if (sweep_stop <= start_inc) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              state      <= SWEEP;
              sweep_busy <= 1'b1;
            end
          end
        end
        SWEEP: begin
          if (sweep_abort) begin
            state      <= FIXED;
            sweep_busy <= 1'b0;
            cfg_ready  <= 1'b1;
          end else if (sample_ce) begin
            if (sweep_nxt[ACC_W] || (sweep_nxt[ACC_W-1:0] >= sweep_stop)) begin
              inc_active <= sweep_stop;
              state      <= DONE;
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              inc_active <= sweep_nxt[ACC_W-1:0];
            end
          end
        end
        DONE: begin
          state     <= FIXED;
          cfg_ready <= 1'b1;
        end
        default: begin
          state      <= FIXED;
          cfg_ready  <= 1'b1;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: a behavioural model queues expected phase samples,
// a monitor pops them on phase_valid; sweep trajectories are checked against a queue of increments.
module tb_nco_sweep_ctrl;

  localparam int ACC_W   = 64;
  localparam int PHASE_W = 10;
  localparam int DIV     = 2;
  localparam logic [ACC_W-1:0] TONE_INC = 64'h3000_0000_0000_0000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [ACC_W-1:0]   cfg_inc = '0;
  logic [PHASE_W-1:0] cfg_offset = '0;
  logic               sweep_start = 1'b0;
  logic               sweep_abort = 1'b0;
  logic [ACC_W-1:0]   sweep_step = '0;
  logic [ACC_W-1:0]   sweep_stop = '0;
  logic               sweep_busy;
  logic               sweep_done;
  logic               sample_ce;
  logic [PHASE_W-1:0] phase_out;
  logic               phase_valid;
  logic               tx_out;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_inc     (cfg_inc),
    .cfg_offset  (cfg_offset),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .sweep_step  (sweep_step),
    .sweep_stop  (sweep_stop),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sample_ce   (sample_ce),
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .tx_out      (tx_out)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model of accumulator, divider and config latency (valid while no sweep runs).
  logic [ACC_W-1:0]   m_acc, m_inc, m_pinc;
  logic [PHASE_W-1:0] m_off, m_poff;
  logic               m_pl, m_tx;
  int                 m_cnt = 0;
  bit                 chk_phase = 1'b0;
  bit                 mon_en = 1'b0;
  logic [PHASE_W-1:0] exp_q[$];
  logic [ACC_W-1:0]   inc_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_acc = '0; m_inc = '0; m_off = '0; m_pl = 1'b0; m_tx = 1'b0; m_cnt = 0;
    end else begin
      if (chk_phase && m_cnt == DIV - 1) exp_q.push_back(m_acc[ACC_W-1 -: PHASE_W] + m_off);
      m_tx  = m_acc[ACC_W-1];
      m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      m_acc = m_acc + m_inc;
      if (m_pl) begin
        m_inc = m_pinc;
        m_off = m_poff;
      end
      m_pl = cfg_valid;
      if (cfg_valid) begin
        m_pinc = cfg_inc;
        m_poff = cfg_offset;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("sample_ce", sample_ce, (m_cnt == DIV - 1));
      if (chk_phase) begin
        check("tx_out", tx_out, m_tx);
        check("phase_valid", phase_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          if (phase_valid) check("phase_out", phase_out, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit phase_chk);
    reset = 1'b1;
    step(2);
    chk_phase = phase_chk;
    exp_q.delete();
    inc_q.delete();
    reset = 1'b0;
  endtask

  task automatic load_cfg(input logic [ACC_W-1:0] inc, input logic [PHASE_W-1:0] off);
    cfg_valid  = 1'b1;
    cfg_inc    = inc;
    cfg_offset = off;
    step(1);
    cfg_valid  = 1'b0;
  endtask

  // Follows a running sweep until it returns to FIXED, comparing each new increment.
  task automatic watch_sweep(input string tag, input int budget, input int jam,
                             input logic [ACC_W-1:0] final_inc);
    logic [ACC_W-1:0] last;
    int dones = 0;
    int i = 0;
    last = dut.inc_active;
    while (i < budget && (sweep_busy || sweep_done)) begin
      cfg_valid = (i < jam);
      cfg_inc   = 64'hDEAD;
      step(1);
      if (sweep_busy || sweep_done) check({tag, "_cfg_ready_low"}, cfg_ready, 1'b0);
      if (dut.inc_active !== last) begin
        if (inc_q.size() != 0) check({tag, "_inc"}, dut.inc_active, inc_q.pop_front());
        else check({tag, "_inc_extra"}, dut.inc_active, last);
        last = dut.inc_active;
      end
      if (sweep_done) dones++;
      i++;
    end
    cfg_valid = 1'b0;
    check({tag, "_timeout"}, sweep_busy, 1'b0);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_final_inc"}, dut.inc_active, final_inc);
    check({tag, "_cfg_ready_back"}, cfg_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int rises;
    logic prev;
    logic [ACC_W-1:0] last;

    // Reset state
    step(1);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_sweep_busy", sweep_busy, 1'b0);
    check("rst_sweep_done", sweep_done, 1'b0);
    check("rst_sample_ce", sample_ce, 1'b0);
    check("rst_phase_valid", phase_valid, 1'b0);
    check("rst_phase_out", phase_out, '0);
    check("rst_tx_out", tx_out, 1'b0);
    step(1);
    mon_en = 1'b1;
    chk_phase = 1'b1;
    reset = 1'b0;
    step(12);
    check("idle_cfg_ready", cfg_ready, 1'b1);
    check("idle_acc", dut.acc, '0);

    // Fixed tone
    do_reset(1'b1);
    load_cfg(TONE_INC, '0);
    check("lat_acc0", dut.acc, '0);
    step(1);
    check("lat_acc1", dut.acc, '0);
    step(1);
    check("lat_acc2", dut.acc, TONE_INC);
    step(30);
    rises = 0;
    prev = tx_out;
    repeat (48) begin
      step(1);
      if (tx_out && !prev) rises++;
      prev = tx_out;
    end
    check("tx_rises_48clk", rises, 9);

    // Phase offset
    do_reset(1'b1);
    load_cfg(TONE_INC, 10'h200);
    step(30);

    // Linear sweep, with config attempts ignored while busy
    do_reset(1'b0);
    sweep_step  = 64'h100;
    sweep_stop  = 64'h350;
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    check("sw_busy", sweep_busy, 1'b1);
    check("sw_cfg_ready", cfg_ready, 1'b0);
    inc_q.push_back(64'h100);
    inc_q.push_back(64'h200);
    inc_q.push_back(64'h300);
    inc_q.push_back(64'h350);
    watch_sweep("sw", 40, 4, 64'h350);

    // Config and start together: config wins; then saturating sweep
    do_reset(1'b0);
    sweep_step  = 64'h200;
    sweep_stop  = '1;
    sweep_start = 1'b1;
    load_cfg(64'hFFFF_FFFF_FFFF_FF00, '0);
    sweep_start = 1'b0;
    check("simul_busy", sweep_busy, 1'b0);
    check("simul_cfg_ready", cfg_ready, 1'b1);
    step(2);
    check("sat_inc_loaded", dut.inc_active, 64'hFFFF_FFFF_FFFF_FF00);
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    inc_q.push_back('1);
    watch_sweep("sat", 20, 0, '1);

    // Abort after two steps
    do_reset(1'b0);
    load_cfg(64'h1000, '0);
    step(1);
    sweep_step  = 64'h10;
    sweep_stop  = 64'h10000;
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    n = 0;
    last = dut.inc_active;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step(1);
      if (dut.inc_active !== last) begin
        n++;
        last = dut.inc_active;
      end
    end
    check("abort_pre_inc", dut.inc_active, 64'h1020);
    sweep_abort = 1'b1;
    step(1);
    sweep_abort = 1'b0;
    check("abort_busy", sweep_busy, 1'b0);
    check("abort_cfg_ready", cfg_ready, 1'b1);
    n = 0;
    repeat (6) begin
      if (sweep_done) n++;
      step(1);
    end
    check("abort_no_done", n, 0);
    check("abort_hold_inc", dut.inc_active, 64'h1020);

    // Abort coinciding with a terminal step
    sweep_stop  = 64'h1030;
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    for (int i = 0; i < 4 && !sample_ce; i++) step(1);
    sweep_abort = 1'b1;
    step(1);
    sweep_abort = 1'b0;
    check("abort_win_done", sweep_done, 1'b0);
    check("abort_win_busy", sweep_busy, 1'b0);
    check("abort_win_inc", dut.inc_active, 64'h1020);

    // Start with stop already reached: straight to DONE
    sweep_stop  = 64'h1000;
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    check("direct_done", sweep_done, 1'b1);
    check("direct_busy", sweep_busy, 1'b0);
    check("direct_cfg_ready", cfg_ready, 1'b0);
    step(1);
    check("direct_done_clr", sweep_done, 1'b0);
    check("direct_cfg_ready_back", cfg_ready, 1'b1);
    check("direct_inc", dut.inc_active, 64'h1020);

    // Endless sweep (zero step) cut by reset
    sweep_step  = '0;
    sweep_stop  = 64'h5000;
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
    step(5);
    check("endless_busy", sweep_busy, 1'b1);
    check("endless_inc", dut.inc_active, 64'h1020);
    reset = 1'b1;
    step(1);
    check("midrst_inc", dut.inc_active, '0);
    check("midrst_busy", sweep_busy, 1'b0);
    check("midrst_acc", dut.acc, '0);
    check("midrst_cfg_ready", cfg_ready, 1'b1);
    reset = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
